// File: rtl/tube_event_reader_if.sv
// ---------------------------------------------------------------------------
// tube_event_reader_if
// Byte stream from the tube event reader toward the readout host.
//   out_data   8  frame byte
//   out_valid  1  out_data holds a byte for the host
//   out_ready  1  host takes the byte on a clock edge where valid && ready
// Handshake: a byte moves on every rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high, and out_data
// stays constant, until that transfer happens. out_ready may change freely.
// ---------------------------------------------------------------------------
interface tube_event_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/tube_event_reader.sv
// ---------------------------------------------------------------------------
// tube_event_reader
// Reader end of the tube counter path. On each event it snapshots the 8-bit
// coincidence count of every tube and streams one framed packet to the host:
//   HDR_BYTE, event number, tube[0] .. tube[N_TUBES-1], checksum
// The checksum is the XOR of the event-number byte and all tube bytes.
// Once the host has taken the checksum, tube_clr is pulsed for CLR_CYCLES
// cycles so the counters start the next event from zero.
// Ports:
//   clk         system clock, rising edge
//   clr         asynchronous active-high reset
//   event_done  1-cycle pulse, tube counters finished for this event
//   tube_data   tube counts, tube i at [8*i+7:8*i]
//   bus         byte stream to the host (master side)
//   tube_clr    clear pulse to all tube counters
//   busy        high from event capture until the clear pulse ends
//   evt_count   frames completed, wraps 255 -> 0
//   drop_count  events ignored while busy, saturates at 255
//   dbg_state   current FSM state
// ---------------------------------------------------------------------------
module tube_event_reader #(
  parameter int          N_TUBES    = 8,
  parameter logic [7:0]  HDR_BYTE   = 8'hA5,
  parameter int          CLR_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   event_done,
  input  logic [8*N_TUBES-1:0]   tube_data,
  tube_event_reader_if.master    bus,
  output logic                   tube_clr,
  output logic                   busy,
  output logic [7:0]             evt_count,
  output logic [7:0]             drop_count,
  output logic [2:0]             dbg_state
);

  localparam int IDX_W = (N_TUBES > 1) ? $clog2(N_TUBES) : 1;
  localparam int CNT_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TUBES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_EVN   = 3'd2,
    S_DATA  = 3'd3,
    S_CKSUM = 3'd4,
    S_CLEAR = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [8*N_TUBES-1:0]   snap_q, snap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             cksum_q, cksum_d;
  logic [7:0]             evt_q, evt_d;
  logic [7:0]             drop_q, drop_d;

  logic                   valid_c;
  logic [7:0]             byte_c;
  logic                   tube_clr_c;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      cksum_q <= 8'h00;
      evt_q   <= 8'h00;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cksum_q <= cksum_d;
      evt_q   <= evt_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cksum_d    = cksum_q;
    evt_d      = evt_q;
    drop_d     = drop_q;
    valid_c    = 1'b0;
    byte_c     = 8'h00;
    tube_clr_c = 1'b0;

    // Any event outside IDLE (CLEAR included) is counted and ignored.
    if (event_done && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (event_done) begin
          snap_d  = tube_data;
          cksum_d = 8'h00;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        valid_c = 1'b1;
        byte_c  = HDR_BYTE;
        if (bus.out_ready) begin
          state_d = S_EVN;
        end
      end
      S_EVN: begin
        valid_c = 1'b1;
        byte_c  = evt_q;
        if (bus.out_ready) begin
          cksum_d = cksum_q ^ evt_q;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        valid_c = 1'b1;
        byte_c  = snap_q[idx_q*8 +: 8];
        if (bus.out_ready) begin
          cksum_d = cksum_q ^ byte_c;
          if (idx_q == LAST_IDX) begin
            state_d = S_CKSUM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_CKSUM: begin
        valid_c = 1'b1;
        byte_c  = cksum_q;
        if (bus.out_ready) begin
          evt_d   = evt_q + 8'd1;
          cnt_d   = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        tube_clr_c = 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out_data  = byte_c;
  assign bus.out_valid = valid_c;
  assign tube_clr      = tube_clr_c;
  // busy and tube_clr both fall on the CLEAR -> IDLE transition.
  assign busy          = (state_q != S_IDLE);
  assign evt_count     = evt_q;
  assign drop_count    = drop_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_tube_event_reader.sv
module tb_tube_event_reader;
  localparam int         N    = 4;
  localparam logic [7:0] HDR  = 8'hA5;
  localparam int         CLRC = 2;
  localparam int         FLEN = N + 3;

  logic           clk;
  logic           clr;
  logic           event_done;
  logic [8*N-1:0] tube_data;
  logic           tube_clr;
  logic           busy;
  logic [7:0]     evt_count;
  logic [7:0]     drop_count;
  logic [2:0]     dbg_state;

  tube_event_reader_if bus ();

  tube_event_reader #(
    .N_TUBES    (N),
    .HDR_BYTE   (HDR),
    .CLR_CYCLES (CLRC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .event_done (event_done),
    .tube_data  (tube_data),
    .bus        (bus),
    .tube_clr   (tube_clr),
    .busy       (busy),
    .evt_count  (evt_count),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         asserts = 0;
  int         fails   = 0;
  logic [7:0] exp_q[$];
  int         exp_total  = 0;
  int         rx_cnt     = 0;
  int         exp_pulses = 0;
  int         pulses     = 0;
  logic [7:0] model_evt  = 8'h00;
  logic [7:0] model_drop = 8'h00;

  int         ready_mode = 0;
  int         ph = 0;
  int         frame_pos = 0;
  int         frm_start = 0;
  int         frm_end   = 0;
  logic [7:0] last_evn  = 8'h55;
  logic       have_hold = 1'b0;
  logic [7:0] hold_data = 8'h00;
  int         clr_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is header, event number, tube bytes in order,
  // then the XOR of everything after the header.
  task automatic push_frame(input logic [8*N-1:0] tubes);
    logic [7:0] x;
    logic [7:0] b;
    exp_q.push_back(HDR);
    exp_q.push_back(model_evt);
    x = model_evt;
    for (int i = 0; i < N; i++) begin
      b = tubes[8*i +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
    exp_q.push_back(x);
    model_evt  = model_evt + 8'd1;
    exp_total += FLEN;
    exp_pulses++;
  endtask

  task automatic note_drop();
    if (model_drop != 8'hFF) model_drop = model_drop + 8'd1;
  endtask

  // ---------------- host ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin
        bus.out_ready = (ph == 0);
        ph = (ph + 1) % 3;
      end
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (clr) begin
      have_hold = 1'b0;
      frame_pos = 0;
      clr_hi    = 0;
    end else begin
      if (have_hold) begin
        chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
        chk("stall_data_held", 32'(bus.out_data), 32'(hold_data));
      end
      have_hold = 1'b0;
      if (bus.out_valid) begin
        chk("busy_while_sending", 32'(busy), 32'd1);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL unexpected_byte: got %02h, no byte expected", bus.out_data);
          end else begin
            chk("frame_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
          end
          rx_cnt++;
          if (frame_pos == 0) frm_start = cyc;
          if (frame_pos == 1) last_evn = bus.out_data;
          if (frame_pos == FLEN - 1) begin
            frm_end   = cyc;
            frame_pos = 0;
          end else begin
            frame_pos++;
          end
        end else begin
          have_hold = 1'b1;
          hold_data = bus.out_data;
        end
      end
      if (tube_clr) begin
        chk("busy_during_clear", 32'(busy), 32'd1);
        chk("no_valid_during_clear", 32'(bus.out_valid), 32'd0);
        clr_hi++;
      end else if (clr_hi != 0) begin
        chk("tube_clr_width", 32'(clr_hi), 32'(CLRC));
        pulses++;
        clr_hi = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_cnt < n && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (rx_cnt < n) begin
      asserts++;
      fails++;
      $display("FAIL rx_timeout: got %0d bytes, expected %0d", rx_cnt, n);
    end
  endtask

  task automatic pulse_event(input logic [8*N-1:0] tubes, input bit accepted);
    @(posedge clk);
    #1;
    tube_data  = tubes;
    event_done = 1'b1;
    if (accepted) push_frame(tubes);
    else note_drop();
    @(posedge clk);
    #1;
    event_done = 1'b0;
    if (accepted) begin
      chk("busy_after_event", 32'(busy), 32'd1);
      chk("valid_one_cycle_after_event", 32'(bus.out_valid), 32'd1);
    end
  endtask

  task automatic settle_check();
    repeat (CLRC + 1) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_tube_clr", 32'(tube_clr), 32'd0);
    chk("evt_count", 32'(evt_count), 32'(model_evt));
    chk("drop_count", 32'(drop_count), 32'(model_drop));
  endtask

  task automatic run_frame(input logic [8*N-1:0] tubes, input bit do_drop, input bit scramble);
    int k;
    pulse_event(tubes, 1'b1);
    if (scramble) tube_data = ~tubes;
    if (do_drop) begin
      k = $urandom_range(1, FLEN - 1);
      wait_rx(exp_total - FLEN + k);
      pulse_event(32'($urandom), 1'b0);
      if (scramble) tube_data = 32'($urandom);
    end
    wait_rx(exp_total);
    settle_check();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    clr        = 1'b1;
    event_done = 1'b0;
    tube_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_tube_clr", 32'(tube_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_evt_count", 32'(evt_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    #1 clr = 1'b0;
    repeat (2) @(posedge clk);

    // Directed frame at full rate: A5 00 01 02 03 FF then XOR checksum.
    ready_mode = 0;
    run_frame(32'hFF030201, 1'b0, 1'b0);
    chk("full_rate_span", 32'(frm_end - frm_start), 32'(FLEN - 1));

    // Same tubes with the host stalling on a 1,0,0 pattern.
    ready_mode = 1;
    run_frame(32'hFF030201, 1'b0, 1'b0);

    // tube_data changes after capture must not reach the frame.
    run_frame(32'h12345678, 1'b0, 1'b1);

    // Event dropped while stalled in DATA, then another dropped during CLEAR.
    ready_mode = 0;
    pulse_event(32'h0A0B0C0D, 1'b1);
    wait_rx(exp_total - FLEN + 3);
    ready_mode = 3;
    repeat (2) @(posedge clk);
    pulse_event(32'hDEADBEEF, 1'b0);
    ready_mode = 0;
    wait_rx(exp_total);
    pulse_event(32'hCAFEF00D, 1'b0);
    settle_check();
    chk("two_drops", 32'(drop_count), 32'd2);

    // Reset in the middle of DATA aborts the frame without a clear pulse.
    pulse_event(32'h44332211, 1'b1);
    wait_rx(exp_total - FLEN + 4);
    #2 clr = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_evt_count", 32'(evt_count), 32'd0);
    chk("abort_drop_count", 32'(drop_count), 32'd0);
    chk("abort_tube_clr", 32'(tube_clr), 32'd0);
    exp_total  -= exp_q.size();
    exp_q.delete();
    exp_pulses--;
    model_evt  = 8'h00;
    model_drop = 8'h00;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    run_frame(32'h11FF2233, 1'b0, 1'b0);
    chk("evn_after_abort", 32'(last_evn), 32'd0);

    // Random tubes, random host ready, random in-frame drops.
    ready_mode = 2;
    for (int i = 0; i < 24; i++) begin
      run_frame((i % 5 == 0) ? 32'hFFFFFFFF : 32'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // 257 events from reset: the last frame's event number has wrapped to 00.
    #2 clr = 1'b1;
    exp_total  -= exp_q.size();
    exp_q.delete();
    model_evt  = 8'h00;
    model_drop = 8'h00;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    ready_mode = 0;
    for (int i = 0; i < 257; i++) begin
      run_frame(32'($urandom), 1'b0, 1'b0);
    end
    chk("wrap_last_evn", 32'(last_evn), 32'd0);
    chk("wrap_evt_count", 32'(evt_count), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("clear_pulse_count", 32'(pulses), 32'(exp_pulses));

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
